// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr datapath multiplexer.
package stream_mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Ceiling log2 with a floor of one bit, usable in parameter defaults.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((w < 31) && ((32'sd1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr wins, wrapping modulo NCH.
module stream_mux_rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx
);

    int              cand_s;
    logic [SELW-1:0] cand_idx_s;
    logic            found_s;

    // Rotating priority search starting one past the previous winner
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s     = (int'(ptr) + k) % NCH;
            cand_idx_s = cand_s[SELW-1:0];
            if (!found_s && req[cand_idx_s]) begin
                found_s   = 1'b1;
                grant_idx = cand_idx_s;
            end else begin
                found_s   = found_s;
            end
        end
        grant[grant_idx] = found_s;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin selection,
// packet-level grant locking and a registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int WIDTH = 3,
    parameter int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_chan
);

    lock_state_t     lock_state_r;
    logic [SELW-1:0] lock_chan_r;
    logic [SELW-1:0] rr_ptr_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [SELW-1:0]  out_chan_r;

    logic [NCH-1:0]   arb_grant_s;
    logic [SELW-1:0]  arb_idx_s;
    logic             adv_s;
    logic             sel_ok_s;
    logic             grant_ok_s;
    logic [SELW-1:0]  grant_s;
    logic             accept_s;
    logic [WIDTH-1:0] beat_data_s;
    logic             beat_last_s;

    stream_mux_rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    assign adv_s    = ~out_valid_r | out_ready;
    assign sel_ok_s = (int'(sel) < NCH);

    // Grant source: locked channel overrides mode, sel and all other requests
    always_comb begin
        grant_ok_s = 1'b0;
        grant_s    = '0;
        if (lock_state_r == ST_LOCKED) begin
            grant_ok_s = 1'b1;
            grant_s    = lock_chan_r;
        end else if (mode == MODE_RR) begin
            grant_ok_s = |arb_grant_s;
            grant_s    = arb_idx_s;
        end else begin
            grant_ok_s = sel_ok_s & in_valid[sel];
            grant_s    = sel;
        end
    end

    // At most one ready bit, and only when the output stage can take a beat
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(grant_s) == i) begin
                in_ready[i] = adv_s & grant_ok_s;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    assign accept_s    = adv_s & grant_ok_s & in_valid[grant_s];
    assign beat_data_s = in_data[int'(grant_s)*WIDTH +: WIDTH];
    assign beat_last_s = in_last[grant_s];

    // Output stage: load on accept, empty on idle advance, hold on stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '1;
            out_last_r  <= 1'b0;
            out_chan_r  <= '0;
        end else if (adv_s) begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= beat_data_s;
                out_last_r  <= beat_last_s;
                out_chan_r  <= grant_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Packet lock and per-packet rotation pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state_r <= ST_UNLOCKED;
            lock_chan_r  <= '0;
            rr_ptr_r     <= SELW'(NCH - 1);
        end else begin
            if (accept_s && beat_last_s) begin
                rr_ptr_r <= grant_s;
            end
            case (lock_state_r)
                ST_UNLOCKED: begin
                    if (accept_s && !beat_last_s) begin
                        lock_state_r <= ST_LOCKED;
                        lock_chan_r  <= grant_s;
                    end
                end
                ST_LOCKED: begin
                    if (accept_s && beat_last_s) begin
                        lock_state_r <= ST_UNLOCKED;
                    end
                end
                default: begin
                    lock_state_r <= ST_UNLOCKED;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed scoreboard bench for stream_mux_rr (NCH=8, WIDTH=3).
module tb_stream_mux_rr;

    localparam int NCH   = 8;
    localparam int WIDTH = 3;
    localparam int SELW  = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;
    logic [SELW-1:0]      out_chan;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    // One cycle: check ready, retire a consumed beat, predict accepted beats.
    task automatic step(input string tag, input logic [NCH-1:0] exp_rdy);
        logic [31:0] e;
        #1;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk({tag, "/sb_depth"}, 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "/beat"}, {25'd0, out_chan, out_data, out_last}, e);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (exp_rdy[i] && in_valid[i]) begin
                sb_q.push_back({25'd0, SELW'(i), in_data[i*WIDTH +: WIDTH], in_last[i]});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = 8'h00;
        in_data   = '0;
        in_last   = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_last",  32'(out_last),  32'd0);
        chk("rst/out_chan",  32'(out_chan),  32'd0);
        chk("rst/out_data",  32'(out_data),  32'd7);
        chk("rst/in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;

        // fixed mode, selected channel idle while others request
        sel = 3'd3; in_valid = 8'hF7; in_last = 8'hFF;
        step("sel_idle", 8'h00);
        chk("sel_idle/out_valid", 32'(out_valid), 32'd0);
        chk("sel_idle/out_data",  32'(out_data),  32'd7);

        // fixed mode, channel 5 single beat
        sel = 3'd5; in_valid = 8'h20; set_data(5, 3'b101);
        step("fix5", 8'h20);
        chk("fix5/out_valid", 32'(out_valid), 32'd1);
        chk("fix5/out_data",  32'(out_data),  32'd5);
        chk("fix5/out_chan",  32'(out_chan),  32'd5);

        // channel 7 last so the rotation starts at channel 0
        sel = 3'd7; in_valid = 8'h80; set_data(7, 3'b011);
        step("fix7", 8'h80);

        // round robin across all channels, single-beat packets
        mode = 1'b1; in_valid = 8'hFF; in_last = 8'hFF;
        for (int i = 0; i < NCH; i++) set_data(i, 3'(i));
        for (int k = 0; k < 9; k++) begin
            step("rr", 8'(32'd1 << (k % NCH)));
            chk("rr/out_chan", 32'(out_chan), 32'(k % NCH));
        end

        // ch2 three-beat packet holds off ch4; mode/sel change mid-packet ignored
        in_valid = 8'h14; in_last = 8'h10; set_data(2, 3'd1); set_data(4, 3'd6);
        step("pkt_b1", 8'h04);
        mode = 1'b0; sel = 3'd4; set_data(2, 3'd2);
        step("pkt_b2", 8'h04);
        mode = 1'b1; in_last = 8'h14; set_data(2, 3'd3);
        step("pkt_b3", 8'h04);
        chk("pkt_b3/out_chan", 32'(out_chan), 32'd2);
        in_valid = 8'h10;
        step("pkt_ch4", 8'h10);
        chk("pkt_ch4/out_chan", 32'(out_chan), 32'd4);
        in_valid = 8'h00;
        step("pkt_drain", 8'h00);

        // output stall with changing inputs
        mode = 1'b0; sel = 3'd6; in_valid = 8'h40; in_last = 8'h40; set_data(6, 3'd3);
        step("stall_load", 8'h40);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 8'h40 | 8'(i);
            set_data(6, 3'(i + 4));
            step("stall", 8'h00);
            chk("stall/out_valid", 32'(out_valid), 32'd1);
            chk("stall/out_data",  32'(out_data),  32'd3);
            chk("stall/out_chan",  32'(out_chan),  32'd6);
        end
        out_ready = 1'b1; in_valid = 8'h40; set_data(6, 3'd5);
        step("resume", 8'h40);
        chk("resume/out_data", 32'(out_data), 32'd5);
        in_valid = 8'h00;
        step("resume_drain", 8'h00);

        // reset in the middle of a locked ch1 packet
        mode = 1'b1; in_valid = 8'h02; in_last = 8'h00; set_data(1, 3'd4);
        step("lk_b1", 8'h02);
        set_data(1, 3'd5);
        step("lk_b2", 8'h02);
        reset = 1'b1;
        #1;
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/out_chan",  32'(out_chan),  32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 8'h03; in_last = 8'h03; set_data(0, 3'd2); set_data(1, 3'd6);
        step("post0", 8'h01);
        chk("post0/out_chan", 32'(out_chan), 32'd0);
        step("post1", 8'h02);
        chk("post1/out_chan", 32'(out_chan), 32'd1);
        in_valid = 8'h00;
        step("post_drain", 8'h00);

        chk("sb_final_depth", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer with valid/ready handshakes and a registered output stage.
- Supersedes the fixed 8:1 combinational mux for datapaths that need backpressure, packet framing and fair arbitration.
- Two modes: fixed (external sel picks the channel) and round-robin (fair rotation among requesting channels).
- Grant locks to one channel for a whole packet, ending at a beat with last set. Sits between multiple producers and a single consumer.

Parameters:
- NCH, 8, number of input channels (2..32).
- WIDTH, 3, data width per channel in bits.
- SELW, $clog2(NCH), width of sel and out_chan.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_valid  input  NCH  per-channel beat valid.
- in_ready  output  NCH  per-channel beat accepted (combinational).
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  NCH  per-channel end-of-packet flag.
- out_valid  output  1  registered output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered payload.
- out_last  output  1  registered end-of-packet flag.
- out_chan  output  SELW  index of the source channel for the current output beat.

Behaviour:
- Reset (async assert, sync release) drives:
  - out_valid = 0, out_last = 0, out_chan = 0.
  - out_data = all ones, matching the default-select value of the fixed mux.
  - lock = 0 and rr_ptr = NCH-1, so channel 0 wins first.
- Advance condition: adv = ~out_valid | out_ready.
- Grant selection, evaluated only when lock = 0:
  - mode 0: grant = sel if sel < NCH and in_valid[sel]; otherwise no grant.
  - mode 1: grant = first i with in_valid[i] = 1, searching from rr_ptr+1 upward modulo NCH.
  - Otherwise no grant.
- When lock = 1, grant = locked channel, regardless of mode, sel or the other valids.
- in_ready[i] = adv & grant_ok & (grant == i). All other in_ready bits are 0. Never more than one bit high.
- Accept (in_valid[g] & in_ready[g]) at a rising edge:
  - out_data <= in_data[g], out_last <= in_last[g], out_chan <= g, out_valid <= 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- If adv = 1 and no accept: out_valid <= 0. out_data, out_last and out_chan hold their values.
- If adv = 0: all output registers hold, even if inputs change.
- Lock state machine, two states:
  - UNLOCKED -> LOCKED on an accepted beat with in_last = 0; the granted index is stored.
  - LOCKED -> UNLOCKED on an accepted beat with in_last = 1.
  - A single-beat packet (last on first beat) never enters LOCKED.
- rr_ptr <= g on every accept with in_last = 1, in either mode. Rotation therefore advances per packet, not per beat.
- Changes to mode or sel while LOCKED are ignored until the packet ends.
- Locked channel drops in_valid mid-packet: no grant to any other channel; wait in LOCKED.
- Full throughput: with out_ready held at 1, one beat per cycle, no bubbles.
- Reset asserted mid-packet: lock cleared and the output beat is discarded; no partial-packet recovery.

Decomposition:
- Shared package: mode encodings MODE_FIXED = 1'b0 and MODE_RR = 1'b1, lock-state enum {ST_UNLOCKED, ST_LOCKED}, and a clog2-style SELW helper.
- One sub-module, rr_arbiter: NCH request vector plus pointer in, one-hot grant plus index out. It is purely combinational, so it can be verified standalone.

Test Plan:
- Reset release, mode 0, sel = 5, in_valid = 8'h20, in_data ch5 = 3'b101, in_last = 1, out_ready = 1 -> in_ready = 8'h20; next cycle out_valid = 1, out_data = 3'b101, out_chan = 5.
- Mode 0, sel = 3, in_valid[3] = 0 (other channels valid) -> in_ready = 0 and out_valid = 0. Before any accept, out_data stays 3'b111.
- Mode 1, all 8 channels valid with single-beat packets, out_ready = 1 -> out_chan sequence 0,1,2,...,7,0 on consecutive cycles.
- Mode 1, ch2 sends a 3-beat packet (last on beat 3) while ch4 is valid throughout -> out_chan = 2,2,2 then 4; in_ready[4] stays 0 during ch2's packet.
- Output stall: out_valid = 1, out_ready = 0 for 4 cycles while inputs change -> out_data and out_chan hold and in_ready = 0. On the first cycle out_ready = 1, the next beat loads one cycle later.
- Reset asserted asynchronously mid-packet (ch1 locked, beat 2 of 4) -> out_valid = 0 immediately. After release with ch0 and ch1 both valid in mode 1, ch0 is granted first.
